apb_node_timeout: RTL

- Parametrised successor to the peripheral APB node: fans one upstream APB slave port out to NB_SLAVE downstream APB masters through a runtime address map.
- Differs from the current node in four ways: it registers both the request and the response paths, and it returns PSLVERR for unmapped or disabled regions.
- It also aborts stalled slaves with a per-transfer timeout and reports that abort on status outputs.
- Sits between the core's APB bridge and the peripheral set (uart, gpio, spi, timer, ...).

---
 rtl/apb_node_pkg.sv | 21 ++
 rtl/apb_addr_decode.sv | 27 ++
 rtl/apb_node_timeout.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/apb_node_pkg.sv
// Shared types for the APB fan-out node with per-transfer timeout.
package apb_node_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    RESP   = 3'd3,
    ERR    = 3'd4
  } state_e;

  localparam int DEFAULT_TIMEOUT = 256;
  localparam int RSP_DATA_W      = 32;

  // Registered upstream response; prdata is sized for the widest supported bus.
  typedef struct packed {
    logic [RSP_DATA_W-1:0] prdata;
    logic                  pslverr;
  } rsp_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Priority region decoder: lowest enabled port whose inclusive range holds the address.
module apb_addr_decode #(
  parameter int NB_SLAVE       = 11,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int IDX_W          = 4
) (
  input  logic [APB_ADDR_WIDTH-1:0]               addr_i,
  input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0] end_addr_i,
  input  logic [NB_SLAVE-1:0]                     slave_en_i,
  output logic                                    hit_o,
  output logic [IDX_W-1:0]                        idx_o
);

  // Scanning downward lets the lowest matching index overwrite higher ones.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NB_SLAVE - 1; i >= 0; i--) begin
      if (slave_en_i[i] && (addr_i >= start_addr_i[i]) && (addr_i <= end_addr_i[i])) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_node_timeout.sv
// APB 1-to-N node with registered request/response paths, PSLVERR on unmapped
// regions, and a per-transfer downstream timeout.
module apb_node_timeout
  import apb_node_pkg::*;
#(
  parameter int  NB_SLAVE       = 11,
  parameter int  APB_ADDR_WIDTH = 32,
  parameter int  APB_DATA_WIDTH = 32,
  parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  localparam int IDX_W          = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0] end_addr_i,
  input  logic [NB_SLAVE-1:0]                     slave_en_i,
  input  logic [APB_ADDR_WIDTH-1:0]               s_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]               s_pwdata_i,
  input  logic                                    s_pwrite_i,
  input  logic                                    s_psel_i,
  input  logic                                    s_penable_i,
  output logic [APB_DATA_WIDTH-1:0]               s_prdata_o,
  output logic                                    s_pready_o,
  output logic                                    s_pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]               m_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]               m_pwdata_o,
  output logic                                    m_pwrite_o,
  output logic [NB_SLAVE-1:0]                     m_psel_o,
  output logic [NB_SLAVE-1:0]                     m_penable_o,
  input  logic [NB_SLAVE-1:0][APB_DATA_WIDTH-1:0] m_prdata_i,
  input  logic [NB_SLAVE-1:0]                     m_pready_i,
  input  logic [NB_SLAVE-1:0]                     m_pslverr_i,
  output logic                                    timeout_o,
  output logic [IDX_W-1:0]                        timeout_idx_o,
  output state_e                                  dbg_state_o
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [APB_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                       write_q, write_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NB_SLAVE-1:0]        psel_q, psel_d;
  logic [NB_SLAVE-1:0]        penable_q, penable_d;
  logic                       pready_q, pready_d;
  rsp_t                       rsp_q, rsp_d;
  logic                       timeout_q, timeout_d;
  logic [IDX_W-1:0]           tidx_q, tidx_d;
  logic                       dec_hit;
  logic [IDX_W-1:0]           dec_idx;

  apb_addr_decode #(
    .NB_SLAVE       (NB_SLAVE),
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
    .IDX_W          (IDX_W)
  ) u_decode (
    .addr_i       (s_paddr_i),
    .start_addr_i (start_addr_i),
    .end_addr_i   (end_addr_i),
    .slave_en_i   (slave_en_i),
    .hit_o        (dec_hit),
    .idx_o        (dec_idx)
  );

  // Every output is computed for the state being entered, so it is a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    idx_d     = idx_q;
    psel_d    = '0;
    penable_d = '0;
    pready_d  = 1'b0;
    rsp_d     = '0;
    timeout_d = 1'b0;
    tidx_d    = tidx_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s_psel_i && !s_penable_i) begin
          addr_d  = s_paddr_i;
          wdata_d = s_pwdata_i;
          write_d = s_pwrite_i;
          idx_d   = dec_idx;
          if (dec_hit) begin
            state_d = SETUP;
            psel_d  = NB_SLAVE'(1) << dec_idx;
          end else begin
            state_d       = ERR;
            pready_d      = 1'b1;
            rsp_d.pslverr = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = NB_SLAVE'(1) << idx_q;
        penable_d = NB_SLAVE'(1) << idx_q;
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (m_pready_i[idx_q]) begin
          state_d       = RESP;
          pready_d      = 1'b1;
          rsp_d.prdata  = RSP_DATA_W'(m_prdata_i[idx_q]);
          rsp_d.pslverr = m_pslverr_i[idx_q];
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d       = RESP;
          pready_d      = 1'b1;
          rsp_d.pslverr = 1'b1;
          timeout_d     = 1'b1;
          tidx_d        = idx_q;
        end else begin
          psel_d    = NB_SLAVE'(1) << idx_q;
          penable_d = NB_SLAVE'(1) << idx_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      psel_q    <= '0;
      penable_q <= '0;
      pready_q  <= 1'b0;
      rsp_q     <= '0;
      timeout_q <= 1'b0;
      tidx_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pready_q  <= pready_d;
      rsp_q     <= rsp_d;
      timeout_q <= timeout_d;
      tidx_q    <= tidx_d;
    end
  end

  assign s_prdata_o    = APB_DATA_WIDTH'(rsp_q.prdata);
  assign s_pslverr_o   = rsp_q.pslverr;
  assign s_pready_o    = pready_q;
  assign m_paddr_o     = addr_q;
  assign m_pwdata_o    = wdata_q;
  assign m_pwrite_o    = write_q;
  assign m_psel_o      = psel_q;
  assign m_penable_o   = penable_q;
  assign timeout_o     = timeout_q;
  assign timeout_idx_o = tidx_q;
  assign dbg_state_o   = state_q;

endmodule
